pwm_regs_multich: RTL and testbench

//  Multi-channel PWM register bank, parametrised successor of the single-channel bank.

---
 rtl/pwm_regs_multich_if.sv | 20 ++
 rtl/pwm_regs_multich.sv | 185 ++++++++++++++++++
 tb/tb_pwm_regs_multich.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_regs_multich_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_regs_multich_if
// Description : Byte-wide register bus between the address decoder and the
//               multi-channel PWM register bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_regs_multich_if #(
   parameter int ADDR_W = 6
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        data_read;
   logic [7:0]        data_write;

   modport master (output read, write, addr, data_write, input  data_read);
   modport slave  (input  read, write, addr, data_write, output data_read);
endinterface
`default_nettype wire

// File: rtl/pwm_regs_multich.sv
`default_nettype none
// ============================================================================
// Module      : pwm_regs_multich
// Description : Multi-channel PWM register bank. Per channel it holds config,
//               staged period/compare values that move to the active copies
//               together at a period boundary, a sticky W1C wrap flag and a
//               combined registered interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_regs_multich #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pwm_regs_multich_if.slave       bus,
   input  logic [NUM_CH*CNT_W-1:0] counter_val,
   input  logic [NUM_CH-1:0]       update_evt,
   output logic [NUM_CH*CNT_W-1:0] period,
   output logic [NUM_CH*CNT_W-1:0] compare1,
   output logic [NUM_CH*CNT_W-1:0] compare2,
   output logic [NUM_CH-1:0]       en,
   output logic [NUM_CH-1:0]       upnotdown,
   output logic [NUM_CH-1:0]       pwm_en,
   output logic [NUM_CH-1:0]       count_reset,
   output logic [NUM_CH*8-1:0]     prescale,
   output logic [NUM_CH*8-1:0]     functions,
   output logic                    irq
);
   localparam int   c_ch_w       = ADDR_W - 4;
   localparam bit   c_has_hi     = (CNT_W > 8);
   localparam logic [3:0] c_off_per_l  = 4'h0;
   localparam logic [3:0] c_off_per_h  = 4'h1;
   localparam logic [3:0] c_off_ctrl   = 4'h2;
   localparam logic [3:0] c_off_cmp1_l = 4'h3;
   localparam logic [3:0] c_off_cmp1_h = 4'h4;
   localparam logic [3:0] c_off_cmp2_l = 4'h5;
   localparam logic [3:0] c_off_cmp2_h = 4'h6;
   localparam logic [3:0] c_off_cnt_rs = 4'h7;
   localparam logic [3:0] c_off_cnt_l  = 4'h8;
   localparam logic [3:0] c_off_cnt_h  = 4'h9;
   localparam logic [3:0] c_off_presc  = 4'hA;
   localparam logic [3:0] c_off_func   = 4'hB;
   localparam logic [3:0] c_off_status = 4'hC;
   localparam logic [3:0] c_off_commit = 4'hD;

   logic [c_ch_w-1:0]   w_chan;
   logic [3:0]          w_off;
   logic [NUM_CH*8-1:0] w_rd_ch;
   logic [NUM_CH-1:0]   w_irq_src;
   logic [7:0]          w_data_read;
   logic                r_irq;

   assign w_chan = bus.addr[ADDR_W-1:4];
   assign w_off  = bus.addr[3:0];

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      // Values are held 16 bits wide; with an 8-bit counter the high bytes stay 0.
      logic [15:0] r_per_stg, r_cmp1_stg, r_cmp2_stg;
      logic [15:0] r_per_act, r_cmp1_act, r_cmp2_act;
      logic [3:0]  r_ctrl;
      logic [7:0]  r_prescale, r_functions;
      logic        r_pending, r_wrap, r_cnt_reset;
      logic        w_wr, w_xfer;
      logic [15:0] w_cnt;
      logic [7:0]  w_rd;

      assign w_wr   = bus.write && (w_chan == c_ch_w'(n));
      // A stopped counter never produces update_evt, so commit immediately when disabled.
      assign w_xfer = r_pending && (update_evt[n] || !r_ctrl[0]);

      if (CNT_W > 8) begin : g_cnt_wide
         assign w_cnt = counter_val[n*CNT_W +: 16];
      end else begin : g_cnt_narrow
         assign w_cnt = {8'h00, counter_val[n*CNT_W +: 8]};
      end

      // Register writes, atomic staging->active transfer and sticky wrap flag
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_per_stg   <= '0;
            r_cmp1_stg  <= '0;
            r_cmp2_stg  <= '0;
            r_per_act   <= '0;
            r_cmp1_act  <= '0;
            r_cmp2_act  <= '0;
            r_ctrl      <= '0;
            r_prescale  <= '0;
            r_functions <= '0;
            r_pending   <= 1'b0;
            r_wrap      <= 1'b0;
            r_cnt_reset <= 1'b0;
         end else begin
            r_cnt_reset <= w_wr && (w_off == c_off_cnt_rs);
            // Transfer reads the pre-edge staging values; a same-edge staging write stays staged.
            if (w_xfer) begin
               r_per_act  <= r_per_stg;
               r_cmp1_act <= r_cmp1_stg;
               r_cmp2_act <= r_cmp2_stg;
               r_pending  <= 1'b0;
            end
            if (update_evt[n]) begin
               r_wrap <= 1'b1;
            end else if (w_wr && (w_off == c_off_status) && bus.data_write[0]) begin
               r_wrap <= 1'b0;
            end
            if (w_wr) begin
               case (w_off)
                  c_off_per_l:  r_per_stg[7:0]  <= bus.data_write;
                  c_off_per_h:  if (c_has_hi) r_per_stg[15:8]  <= bus.data_write;
                  c_off_ctrl:   r_ctrl          <= bus.data_write[3:0];
                  c_off_cmp1_l: r_cmp1_stg[7:0] <= bus.data_write;
                  c_off_cmp1_h: if (c_has_hi) r_cmp1_stg[15:8] <= bus.data_write;
                  c_off_cmp2_l: r_cmp2_stg[7:0] <= bus.data_write;
                  c_off_cmp2_h: if (c_has_hi) r_cmp2_stg[15:8] <= bus.data_write;
                  c_off_presc:  r_prescale      <= bus.data_write;
                  c_off_func:   r_functions     <= bus.data_write;
                  // Arming wins over the transfer clear so a commit is never lost.
                  c_off_commit: if (bus.data_write[0]) r_pending <= 1'b1;
                  default: ;
               endcase
            end
         end
      end

      // Per-channel read data; period/compare offsets expose the staging copies
      always_comb begin
         w_rd = 8'h00;
         case (w_off)
            c_off_per_l:  w_rd = r_per_stg[7:0];
            c_off_per_h:  w_rd = r_per_stg[15:8];
            c_off_ctrl:   w_rd = {4'h0, r_ctrl};
            c_off_cmp1_l: w_rd = r_cmp1_stg[7:0];
            c_off_cmp1_h: w_rd = r_cmp1_stg[15:8];
            c_off_cmp2_l: w_rd = r_cmp2_stg[7:0];
            c_off_cmp2_h: w_rd = r_cmp2_stg[15:8];
            c_off_cnt_l:  w_rd = w_cnt[7:0];
            c_off_cnt_h:  w_rd = w_cnt[15:8];
            c_off_presc:  w_rd = r_prescale;
            c_off_func:   w_rd = r_functions;
            c_off_status: w_rd = {6'h00, r_pending, r_wrap};
            default:      w_rd = 8'h00;
         endcase
      end

      assign w_rd_ch[n*8 +: 8]            = w_rd;
      assign w_irq_src[n]                 = r_wrap & r_ctrl[3];
      assign period[n*CNT_W +: CNT_W]     = r_per_act[CNT_W-1:0];
      assign compare1[n*CNT_W +: CNT_W]   = r_cmp1_act[CNT_W-1:0];
      assign compare2[n*CNT_W +: CNT_W]   = r_cmp2_act[CNT_W-1:0];
      assign en[n]                        = r_ctrl[0];
      assign upnotdown[n]                 = r_ctrl[1];
      assign pwm_en[n]                    = r_ctrl[2];
      assign count_reset[n]               = r_cnt_reset;
      assign prescale[n*8 +: 8]           = r_prescale;
      assign functions[n*8 +: 8]          = r_functions;
   end

   // Channel select for read data; unpopulated channels and idle bus read 0
   always_comb begin
      w_data_read = 8'h00;
      if (bus.read) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_chan == c_ch_w'(i)) begin
               w_data_read = w_rd_ch[i*8 +: 8];
            end
         end
      end
   end

   assign bus.data_read = w_data_read;

   // Interrupt registered from the wrap flags, lagging them by one cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |w_irq_src;
      end
   end

   assign irq = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_pwm_regs_multich.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_regs_multich
// Description : Self-checking bench for pwm_regs_multich: directed scenarios
//               plus random traffic against an array-based reference model,
//               and a narrow (2 channel, 8 bit) instance for the size limits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_regs_multich;
   localparam int NCH = 4;
   localparam int CW  = 16;
   localparam int AW  = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NCH*CW-1:0] counter_val, period, compare1, compare2;
   logic [NCH-1:0]    update_evt, en, upnotdown, pwm_en, count_reset;
   logic [NCH*8-1:0]  prescale, functions;
   logic              irq;

   logic [15:0] n_counter_val, n_period, n_compare1, n_compare2, n_prescale, n_functions;
   logic [1:0]  n_update_evt, n_en, n_upnotdown, n_pwm_en, n_count_reset;
   logic        n_irq;

   pwm_regs_multich_if #(.ADDR_W(AW)) bus ();
   pwm_regs_multich_if #(.ADDR_W(6))  nbus ();

   pwm_regs_multich #(.NUM_CH(NCH), .CNT_W(CW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .counter_val(counter_val),
      .update_evt(update_evt), .period(period), .compare1(compare1),
      .compare2(compare2), .en(en), .upnotdown(upnotdown), .pwm_en(pwm_en),
      .count_reset(count_reset), .prescale(prescale), .functions(functions), .irq(irq)
   );

   pwm_regs_multich #(.NUM_CH(2), .CNT_W(8), .ADDR_W(6)) dut_n (
      .clk(clk), .rst_n(rst_n), .bus(nbus), .counter_val(n_counter_val),
      .update_evt(n_update_evt), .period(n_period), .compare1(n_compare1),
      .compare2(n_compare2), .en(n_en), .upnotdown(n_upnotdown), .pwm_en(n_pwm_en),
      .count_reset(n_count_reset), .prescale(n_prescale), .functions(n_functions), .irq(n_irq)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: [ch][0]=period, [1]=compare1, [2]=compare2
   logic [15:0] m_stg [4][3];
   logic [15:0] m_act [4][3];
   logic [3:0]  m_ctrl [4];
   logic [7:0]  m_pre [4];
   logic [7:0]  m_fun [4];
   logic        m_pend [4];
   logic        m_wrap [4];
   logic        m_cres [4];
   logic        m_irq;

   task automatic model_clear();
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 3; k++) begin
            m_stg[c][k] = 16'h0;
            m_act[c][k] = 16'h0;
         end
         m_ctrl[c] = 4'h0; m_pre[c] = 8'h0; m_fun[c] = 8'h0;
         m_pend[c] = 1'b0; m_wrap[c] = 1'b0; m_cres[c] = 1'b0;
      end
      m_irq = 1'b0;
   endtask

   // One clock of bus/update stimulus on the main DUT, model advanced alongside
   task automatic step(input logic wr, input logic [5:0] a, input logic [7:0] d, input logic [3:0] upd);
      logic [15:0] n_stg [4][3];
      logic [15:0] n_act [4][3];
      logic [3:0]  n_ctrl [4];
      logic [7:0]  n_pre [4];
      logic [7:0]  n_fun [4];
      logic        n_pend [4];
      logic        n_wrap [4];
      logic        n_cres [4];
      logic        n_irq_m;
      int          ch;
      bus.write = wr; bus.addr = a; bus.data_write = d; bus.read = 1'b0;
      update_evt = upd;
      n_stg = m_stg; n_act = m_act; n_ctrl = m_ctrl; n_pre = m_pre; n_fun = m_fun;
      n_pend = m_pend; n_wrap = m_wrap; n_cres = m_cres;
      n_irq_m = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_irq_m = n_irq_m | (m_wrap[c] & m_ctrl[c][3]);
         n_cres[c] = 1'b0;
         if (m_pend[c] && (upd[c] || !m_ctrl[c][0])) begin
            for (int k = 0; k < 3; k++) n_act[c][k] = m_stg[c][k];
            n_pend[c] = 1'b0;
         end
         if (upd[c]) n_wrap[c] = 1'b1;
      end
      if (wr) begin
         ch = int'(a[5:4]);
         case (a[3:0])
            4'h0: n_stg[ch][0][7:0]  = d;
            4'h1: n_stg[ch][0][15:8] = d;
            4'h2: n_ctrl[ch] = d[3:0];
            4'h3: n_stg[ch][1][7:0]  = d;
            4'h4: n_stg[ch][1][15:8] = d;
            4'h5: n_stg[ch][2][7:0]  = d;
            4'h6: n_stg[ch][2][15:8] = d;
            4'h7: n_cres[ch] = 1'b1;
            4'hA: n_pre[ch] = d;
            4'hB: n_fun[ch] = d;
            4'hC: if (d[0] && !upd[ch]) n_wrap[ch] = 1'b0;
            4'hD: if (d[0]) n_pend[ch] = 1'b1;
            default: ;
         endcase
      end
      @(posedge clk); #1;
      m_stg = n_stg; m_act = n_act; m_ctrl = n_ctrl; m_pre = n_pre; m_fun = n_fun;
      m_pend = n_pend; m_wrap = n_wrap; m_cres = n_cres; m_irq = n_irq_m;
      bus.write = 1'b0; update_evt = '0;
   endtask

   function automatic logic [7:0] model_read(input logic [5:0] a);
      int ch;
      ch = int'(a[5:4]);
      case (a[3:0])
         4'h0: return m_stg[ch][0][7:0];
         4'h1: return m_stg[ch][0][15:8];
         4'h2: return {4'h0, m_ctrl[ch]};
         4'h3: return m_stg[ch][1][7:0];
         4'h4: return m_stg[ch][1][15:8];
         4'h5: return m_stg[ch][2][7:0];
         4'h6: return m_stg[ch][2][15:8];
         4'h8: return counter_val[ch*16 +: 8];
         4'h9: return counter_val[ch*16+8 +: 8];
         4'hA: return m_pre[ch];
         4'hB: return m_fun[ch];
         4'hC: return {6'h0, m_pend[ch], m_wrap[ch]};
         default: return 8'h00;
      endcase
   endfunction

   // Sample a read in the quiet window, then let one idle cycle pass
   task automatic bus_read(input logic [5:0] a, output logic [7:0] d);
      bus.read = 1'b1; bus.addr = a;
      #1;
      d = bus.data_read;
      bus.read = 1'b0;
      step(1'b0, 6'h00, 8'h00, 4'h0);
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1; model_clear();
      for (int i = 0; i < 20; i++)
         step(1'b1, 6'($urandom), 8'($urandom), 4'($urandom));
      rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1; model_clear();
      counter_val = '0;
      vectors++;
      if ({period, compare1, compare2} !== '0) begin
         miscompares++; $display("FAIL reset_active: got %h required 0", {period, compare1, compare2});
      end
      vectors++;
      if ({en, upnotdown, pwm_en, count_reset, irq} !== '0) begin
         miscompares++; $display("FAIL reset_ctrl: got %h required 0", {en, upnotdown, pwm_en, count_reset, irq});
      end
      vectors++;
      if ({prescale, functions} !== '0) begin
         miscompares++; $display("FAIL reset_presc_func: got %h required 0", {prescale, functions});
      end
      vectors++;
      if ({n_period, n_en, n_count_reset, n_prescale, n_irq} !== '0) begin
         miscompares++; $display("FAIL reset_narrow: got %h required 0", {n_period, n_en, n_count_reset, n_prescale, n_irq});
      end
      for (int a = 0; a < 64; a++) begin
         bus_read(6'(a), rd);
         vectors++;
         if (rd !== 8'h00) begin
            miscompares++; $display("FAIL reset_read addr %h: got %h required 00", a, rd);
         end
      end
   endtask

   task automatic test_commit_enabled();
      logic [7:0] rd;
      step(1'b1, 6'h12, 8'h01, 4'h0);
      step(1'b1, 6'h10, 8'h34, 4'h0);
      step(1'b1, 6'h11, 8'h12, 4'h0);
      step(1'b1, 6'h13, 8'h00, 4'h0);
      step(1'b1, 6'h14, 8'h08, 4'h0);
      step(1'b1, 6'h1D, 8'h01, 4'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 6'h00, 8'h00, 4'h0);
      vectors++;
      if (period[31:16] !== 16'h0000) begin
         miscompares++; $display("FAIL commit_en_hold: period1 %h required 0000", period[31:16]);
      end
      bus_read(6'h1C, rd);
      vectors++;
      if (rd !== 8'h02) begin
         miscompares++; $display("FAIL commit_en_pending: status %h required 02", rd);
      end
      step(1'b0, 6'h00, 8'h00, 4'b0010);
      vectors++;
      if ({period[31:16], compare1[31:16]} !== {16'h1234, 16'h0800}) begin
         miscompares++; $display("FAIL commit_en_xfer: got %h required 12340800", {period[31:16], compare1[31:16]});
      end
      bus_read(6'h1C, rd);
      vectors++;
      if (rd !== 8'h01) begin
         miscompares++; $display("FAIL commit_en_status: status %h required 01", rd);
      end
   endtask

   task automatic test_commit_disabled();
      logic [7:0] rd;
      step(1'b1, 6'h00, 8'hCD, 4'h0);
      step(1'b1, 6'h01, 8'hAB, 4'h0);
      step(1'b1, 6'h05, 8'h11, 4'h0);
      step(1'b1, 6'h06, 8'h22, 4'h0);
      step(1'b1, 6'h0D, 8'h01, 4'h0);
      vectors++;
      if (period[15:0] !== 16'h0000) begin
         miscompares++; $display("FAIL commit_dis_arm_edge: period0 %h required 0000", period[15:0]);
      end
      bus_read(6'h0C, rd);
      vectors++;
      if (rd !== 8'h02) begin
         miscompares++; $display("FAIL commit_dis_pending: status %h required 02", rd);
      end
      vectors++;
      if ({period[15:0], compare2[15:0]} !== {16'hABCD, 16'h2211}) begin
         miscompares++; $display("FAIL commit_dis_xfer: got %h required ABCD2211", {period[15:0], compare2[15:0]});
      end
      // Staging write on the transfer edge must stay staged
      step(1'b1, 6'h00, 8'h55, 4'h0);
      step(1'b1, 6'h0D, 8'h01, 4'h0);
      step(1'b1, 6'h00, 8'h66, 4'h0);
      vectors++;
      if (period[15:0] !== 16'hAB55) begin
         miscompares++; $display("FAIL staging_excluded: period0 %h required AB55", period[15:0]);
      end
      bus_read(6'h00, rd);
      vectors++;
      if (rd !== 8'h66 || period[15:0] !== 16'hAB55) begin
         miscompares++; $display("FAIL staging_kept: read %h period %h required 66 AB55", rd, period[15:0]);
      end
   endtask

   task automatic test_wrap_irq();
      logic [7:0] rd;
      step(1'b1, 6'h22, 8'h08, 4'h0);
      step(1'b0, 6'h00, 8'h00, 4'b0100);
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++; $display("FAIL irq_latency: irq %b required 0", irq);
      end
      step(1'b0, 6'h00, 8'h00, 4'h0);
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++; $display("FAIL irq_set: irq %b required 1", irq);
      end
      step(1'b1, 6'h2C, 8'h01, 4'b0100);
      bus_read(6'h2C, rd);
      vectors++;
      if (rd !== 8'h01) begin
         miscompares++; $display("FAIL wrap_set_wins: status %h required 01", rd);
      end
      step(1'b1, 6'h2C, 8'h01, 4'h0);
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++; $display("FAIL irq_clear_lag: irq %b required 1", irq);
      end
      bus_read(6'h2C, rd);
      vectors++;
      if (rd !== 8'h00 || irq !== 1'b0) begin
         miscompares++; $display("FAIL wrap_w1c: status %h irq %b required 00 0", rd, irq);
      end
   endtask

   task automatic test_cnt_reset();
      logic [7:0] rd;
      step(1'b1, 6'h37, 8'($urandom), 4'h0);
      vectors++;
      if (count_reset !== 4'b1000) begin
         miscompares++; $display("FAIL cnt_reset_pulse: got %b required 1000", count_reset);
      end
      step(1'b0, 6'h00, 8'h00, 4'h0);
      vectors++;
      if (count_reset !== 4'b0000) begin
         miscompares++; $display("FAIL cnt_reset_clear: got %b required 0000", count_reset);
      end
      step(1'b1, 6'h37, 8'h00, 4'h0);
      step(1'b1, 6'h37, 8'h00, 4'h0);
      vectors++;
      if (count_reset !== 4'b1000) begin
         miscompares++; $display("FAIL cnt_reset_b2b: got %b required 1000", count_reset);
      end
      counter_val = {$urandom, $urandom};
      bus_read(6'h37, rd);
      vectors++;
      if (rd !== 8'h00 || count_reset !== 4'b0000) begin
         miscompares++; $display("FAIL cnt_reset_read: read %h pulse %b required 00 0000", rd, count_reset);
      end
      bus_read(6'h39, rd);
      vectors++;
      if (rd !== counter_val[63:56]) begin
         miscompares++; $display("FAIL cnt_read_h: got %h required %h", rd, counter_val[63:56]);
      end
   endtask

   task automatic test_random();
      logic [63:0] e_per, e_c1, e_c2;
      logic [31:0] e_pre, e_fun;
      logic [3:0]  e_en, e_ud, e_pe, e_cr, upd;
      logic [5:0]  a;
      logic [7:0]  rd, exp;
      for (int it = 0; it < 400; it++) begin
         counter_val = {$urandom, $urandom};
         for (int c = 0; c < 4; c++) upd[c] = ($urandom_range(0, 7) == 0);
         step(1'($urandom), 6'($urandom), 8'($urandom), upd);
         for (int c = 0; c < 4; c++) begin
            e_per[c*16 +: 16] = m_act[c][0];
            e_c1[c*16 +: 16]  = m_act[c][1];
            e_c2[c*16 +: 16]  = m_act[c][2];
            e_pre[c*8 +: 8]   = m_pre[c];
            e_fun[c*8 +: 8]   = m_fun[c];
            e_en[c] = m_ctrl[c][0]; e_ud[c] = m_ctrl[c][1]; e_pe[c] = m_ctrl[c][2];
            e_cr[c] = m_cres[c];
         end
         vectors++;
         if ({period, compare1, compare2} !== {e_per, e_c1, e_c2}) begin
            miscompares++; $display("FAIL rnd_active it %0d: got %h required %h", it, {period, compare1, compare2}, {e_per, e_c1, e_c2});
         end
         vectors++;
         if ({en, upnotdown, pwm_en, count_reset, irq} !== {e_en, e_ud, e_pe, e_cr, m_irq}) begin
            miscompares++; $display("FAIL rnd_ctrl it %0d: got %h required %h", it, {en, upnotdown, pwm_en, count_reset, irq}, {e_en, e_ud, e_pe, e_cr, m_irq});
         end
         vectors++;
         if ({prescale, functions} !== {e_pre, e_fun}) begin
            miscompares++; $display("FAIL rnd_presc_func it %0d: got %h required %h", it, {prescale, functions}, {e_pre, e_fun});
         end
         vectors++;
         if (bus.data_read !== 8'h00) begin
            miscompares++; $display("FAIL rnd_idle_read it %0d: got %h required 00", it, bus.data_read);
         end
         if (it % 3 == 0) begin
            a = 6'($urandom);
            exp = model_read(a);
            bus_read(a, rd);
            vectors++;
            if (rd !== exp) begin
               miscompares++; $display("FAIL rnd_read it %0d addr %h: got %h required %h", it, a, rd, exp);
            end
         end
      end
   endtask

   task automatic nwrite(input logic [5:0] a, input logic [7:0] d);
      nbus.write = 1'b1; nbus.addr = a; nbus.data_write = d;
      @(posedge clk); #1;
      nbus.write = 1'b0;
   endtask

   task automatic test_narrow();
      logic [7:0] rd;
      n_counter_val = 16'h5AC3;
      nwrite(6'h32, 8'h0F);
      nwrite(6'h30, 8'hFF);
      nbus.read = 1'b1; nbus.addr = 6'h32; #1; rd = nbus.data_read;
      vectors++;
      if (rd !== 8'h00 || n_en !== 2'b00) begin
         miscompares++; $display("FAIL narrow_bad_chan: read %h en %b required 00 00", rd, n_en);
      end
      nbus.read = 1'b0;
      nwrite(6'h01, 8'hFF);
      nwrite(6'h00, 8'hAB);
      nbus.read = 1'b1; nbus.addr = 6'h01; #1; rd = nbus.data_read;
      vectors++;
      if (rd !== 8'h00) begin
         miscompares++; $display("FAIL narrow_period_h: read %h required 00", rd);
      end
      nbus.addr = 6'h00; #1; rd = nbus.data_read;
      vectors++;
      if (rd !== 8'hAB) begin
         miscompares++; $display("FAIL narrow_period_l: read %h required AB", rd);
      end
      nbus.addr = 6'h19; #1; rd = nbus.data_read;
      vectors++;
      if (rd !== 8'h00) begin
         miscompares++; $display("FAIL narrow_cnt_h: read %h required 00", rd);
      end
      nbus.read = 1'b0;
      nwrite(6'h0D, 8'h01);
      @(posedge clk); #1;
      vectors++;
      if (n_period !== 16'h00AB) begin
         miscompares++; $display("FAIL narrow_commit: period %h required 00AB", n_period);
      end
   endtask

   initial begin
      bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.data_write = '0;
      nbus.read = 1'b0; nbus.write = 1'b0; nbus.addr = '0; nbus.data_write = '0;
      counter_val = '0; update_evt = '0; n_counter_val = '0; n_update_evt = '0;
      model_clear();
      @(posedge clk); #1;
      test_reset();
      test_commit_enabled();
      test_commit_disabled();
      test_wrap_irq();
      test_cnt_reset();
      test_random();
      test_narrow();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
